// File: rtl/bounded_step_scheduler.sv
// Round-robin scheduler sharing one bounded step/total counter pair between N_REQ requesters.
// Optional invariant checker (sticky err plus simulation assertions) enabled by BSS_INVARIANT_CHECK_EN.
module bounded_step_scheduler #(
  parameter int N_REQ = 4,
  parameter int CW    = 10,
  parameter int LIMIT = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         step,
  output logic [CW-1:0]         total,
  output logic [N_REQ*CW-1:0]   tally,
  output logic                  err
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  rr;
  logic           restart;

  // First asserted request at or after pointer p, wrapping modulo N_REQ.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [RW-1:0] p);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [RW-1:0]    sel;
    int               idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(p) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = RW'(idx);
      if (!found && r[sel]) begin
        g[sel] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] cap);
    return (v < cap) ? v + CW'(1) : v;
  endfunction

  assign restart = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if ((|grant) && (step == LIM)) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    done  = (state == DONE);
    grant = '0;
    if ((state == RUN) && (step <= LIM)) grant = rr_pick(req, rr);
  end

  // Counter bank: cleared on reset or run start, advanced by exactly one per grant.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      step  <= CW'(1);
      total <= '0;
      tally <= '0;
      rr    <= '0;
    end else if (|grant) begin
      step  <= sat_inc(step, LIM + CW'(1));
      total <= sat_inc(total, LIM);
      for (int k = 0; k < N_REQ; k++) begin
        if (grant[k]) begin
          tally[k*CW +: CW] <= tally[k*CW +: CW] + CW'(1);
          rr <= (k == N_REQ - 1) ? '0 : RW'(k + 1);
        end
      end
    end
  end

`ifdef BSS_INVARIANT_CHECK_EN
  logic [CW+3:0] tally_sum;
  logic          viol;

  always_comb begin
    tally_sum = '0;
    for (int k = 0; k < N_REQ; k++) tally_sum = tally_sum + (CW+4)'(tally[k*CW +: CW]);
    viol = (step != total + CW'(1))
        || (tally_sum != (CW+4)'(total))
        || ((step > LIM) && (total != LIM) && (total != '0))
        || ((grant & (grant - N_REQ'(1))) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst)       err <= 1'b0;
    else if (viol) err <= 1'b1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (step == total + CW'(1));
      assert (tally_sum == (CW+4)'(total));
      assert (!((step > LIM) && (total != LIM) && (total != '0)));
      assert ((grant & (grant - N_REQ'(1))) == '0);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bounded_step_scheduler.sv
// Directed bench for bounded_step_scheduler: reset, idle run, rotation, single requester, restart and mid-run reset.
module tb_bounded_step_scheduler;
  localparam int N_REQ = 4;
  localparam int CW    = 10;
  localparam int LIMIT = 250;

  logic                clk = 1'b0;
  logic                rst, start;
  logic [N_REQ-1:0]    req, grant;
  logic                busy, done, err;
  logic [CW-1:0]       step, total;
  logic [N_REQ*CW-1:0] tally;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bounded_step_scheduler #(.N_REQ(N_REQ), .CW(CW), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .grant(grant),
    .busy(busy), .done(done), .step(step), .total(total), .tally(tally), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] tal(input int k);
    return tally[k*CW +: CW];
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; req = '0;
    tick; tick;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 1);
    chk("rst_total", total, 0);
    chk("rst_tally", tally, 0);
    chk("rst_err", err, 0);

    // Run with no requests: counters stay at their start values.
    rst = 1'b0; start = 1'b1; tick;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_busy", busy, 1);
      chk("idle_grant", grant, 0);
      chk("idle_step", step, 1);
      chk("idle_total", total, 0);
      tick;
    end

    // All requesters asserted: grants rotate 0,1,2,3.
    rst = 1'b1; tick;
    rst = 1'b0; start = 1'b1; tick;
    start = 1'b0; req = 4'b1111;
    for (int c = 0; c < LIMIT; c++) begin
      #1;
      chk("rot_grant", grant, 4'b0001 << (c % 4));
      chk("rot_step", step, c + 1);
      chk("rot_total", total, c);
      tick;
    end
    #1;
    chk("rot_done", done, 1);
    chk("rot_busy", busy, 0);
    chk("rot_end_step", step, 251);
    chk("rot_end_total", total, 250);
    chk("rot_end_grant", grant, 0);
    chk("rot_tally0", tal(0), 63);
    chk("rot_tally1", tal(1), 63);
    chk("rot_tally2", tal(2), 62);
    chk("rot_tally3", tal(3), 62);

    // Single requester 2 gets every grant.
    rst = 1'b1; req = '0; tick;
    rst = 1'b0; start = 1'b1; tick;
    start = 1'b0; req = 4'b0100;
    for (int c = 0; c < LIMIT; c++) begin
      #1;
      chk("one_grant", grant, 4'b0100);
      tick;
    end
    #1;
    chk("one_done", done, 1);
    chk("one_tally0", tal(0), 0);
    chk("one_tally1", tal(1), 0);
    chk("one_tally2", tal(2), 250);
    chk("one_tally3", tal(3), 0);
    for (int c = 0; c < 5; c++) begin
      tick; #1;
      chk("hold_step", step, 251);
      chk("hold_total", total, 250);
      chk("hold_tally2", tal(2), 250);
      chk("hold_grant", grant, 0);
      chk("hold_done", done, 1);
    end

    // Restart from DONE, then a start during RUN is ignored.
    start = 1'b1; #1;
    chk("done_start_grant", grant, 0);
    tick;
    start = 1'b0; req = 4'b1111; #1;
    chk("restart_busy", busy, 1);
    chk("restart_step", step, 1);
    chk("restart_total", total, 0);
    chk("restart_tally2", tal(2), 0);
    repeat (5) tick;
    #1;
    chk("run5_total", total, 5);
    start = 1'b1; #1;
    chk("run5_grant", grant, 4'b0010);
    tick;
    start = 1'b0; #1;
    chk("ignore_busy", busy, 1);
    chk("ignore_total", total, 6);
    chk("ignore_step", step, 7);

    // Reset in the middle of a run discards it.
    repeat (94) tick;
    #1;
    chk("mid_total", total, 100);
    rst = 1'b1; tick;
    rst = 1'b0; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_step", step, 1);
    chk("midrst_total", total, 0);
    chk("midrst_tally", tally, 0);
    chk("midrst_grant", grant, 0);
    start = 1'b1; #1;
    chk("start_req_grant", grant, 0);
    tick;
    start = 1'b0; #1;
    chk("fresh_busy", busy, 1);
    chk("fresh_grant", grant, 4'b0001);
    tick; #1;
    chk("fresh_total", total, 1);
    chk("fresh_tally0", tal(0), 1);
    chk("final_err", err, 0);

`ifdef BSS_INVARIANT_CHECK_EN
    rst = 1'b1; req = '0; tick;
    rst = 1'b0; start = 1'b1; tick;
    start = 1'b0; req = 4'b0001; tick; tick;
    req = '0; #1;
    chk("inv_step", step, 3);
    force dut.total = 10'd7;
    tick;
    release dut.total;
    #1;
    chk("inv_err_set", err, 1);
    tick; tick; #1;
    chk("inv_err_sticky", err, 1);
    rst = 1'b1; tick;
    rst = 1'b0; #1;
    chk("inv_err_clear", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
